// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Responder end of the CPU data-memory port. It accepts one read or write
// request at a time, holds it for a fixed LATENCY cycles, then completes it
// with a single-cycle mem_resp pulse. Storage is a word-addressed array of
// 2**ADDR_BITS 32-bit words. Address bits above the index alias, and bits
// [1:0] are ignored.
//
// Ports
//   clk              clock; all state changes on posedge
//   rst              synchronous, active-high reset
//   mem_read         read request, held by the initiator until mem_resp
//   mem_write        write request, held by the initiator until mem_resp
//   mem_byte_enable  byte-lane enables; bit i covers bits 8i+7:8i
//   mem_address      byte address; index = mem_address[ADDR_BITS+1:2]
//   mem_wdata        lane-aligned write data
//   mem_rdata        read data; valid only while mem_resp is high
//   mem_resp         one-cycle completion pulse
//   busy             high while a request is accepted but not yet answered
//   proto_err        sticky flag: initiator broke the hold-stable rule, or
//                    raised read and write together
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int ADDR_BITS = 10,
   parameter int LATENCY   = 3     // legal range 1..15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_resp,
   output logic        busy,
   output logic        proto_err
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [3:0]           cnt;
   logic [ADDR_BITS-1:0] lat_idx;
   logic [3:0]           lat_be;
   logic [31:0]          lat_wdata;
   logic                 lat_wr;

   logic [31:0]          mem [DEPTH];

   logic                 req;
   logic [ADDR_BITS-1:0] cur_idx;
   logic                 hold_ok;
   logic                 unused_addr_bits;

   assign req     = mem_read | mem_write;
   assign cur_idx = mem_address[ADDR_BITS+1:2];

   // The request is still the one that was accepted. Read and write raised
   // together count as a write, so the current op is simply mem_write.
   assign hold_ok = req && (cur_idx == lat_idx) && (mem_write == lat_wr);

   // Upper address bits alias and bits [1:0] are ignored.
   assign unused_addr_bits = ^{mem_address[31:ADDR_BITS+2], mem_address[1:0]};

   // ---------------------------------------------------------------- state reg
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // ---------------------------------------------------------- next-state comb
   // NOTE: state_nxt is defaulted before the case, so no path leaves it
   // unassigned and no latch can be inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (req) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
         S_WAIT: begin
            if (!hold_ok)        state_nxt = S_IDLE;   // abort: no resp, no write
            else if (cnt == 4'd1) state_nxt = S_RESP;
         end
         S_RESP:  state_nxt = S_IDLE;  // requests seen during RESP are not accepted
         default: state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------- output comb
   always_comb begin
      mem_resp = (state == S_RESP);
      busy     = (state != S_IDLE);
   end

   // ------------------------------------------------ request latch / datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         lat_idx   <= '0;
         lat_be    <= '0;
         lat_wdata <= '0;
         lat_wr    <= 1'b0;
         mem_rdata <= '0;
         proto_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  lat_idx   <= cur_idx;
                  lat_be    <= mem_byte_enable;
                  lat_wdata <= mem_wdata;
                  lat_wr    <= mem_write;
                  cnt       <= 4'(LATENCY - 1);
                  if (mem_read && mem_write) proto_err <= 1'b1;
                  // With a single-cycle latency, RESP follows immediately,
                  // so read data must be loaded on the accepting edge.
                  if (LATENCY == 1 && !mem_write) mem_rdata <= mem[cur_idx];
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (!hold_ok)                    proto_err <= 1'b1;
               else if (cnt == 4'd1 && !lat_wr) mem_rdata <= mem[lat_idx];
            end
            S_RESP: begin
               // A violation here is flagged but the transaction still completes.
               if (!hold_ok) proto_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------ storage array
   // NOTE: the array has no reset; its contents survive rst. Only the commit is
   // gated by rst, so a write caught in RESP at the reset edge is dropped.
   always_ff @(posedge clk) begin
      if (!rst && state == S_RESP && lat_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Two instances: u=0 with LATENCY=3 and u=1 with LATENCY=1, both ADDR_BITS=10.
// A word-array reference model tracks what each memory should contain and
// which words are fully known. Every transaction is checked for response
// latency, busy during the wait, and read data (or held read data on writes).
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read  [2];
   logic        mem_write [2];
   logic [3:0]  be        [2];
   logic [31:0] addr      [2];
   logic [31:0] wdata     [2];
   logic [31:0] rdata     [2];
   logic        resp      [2];
   logic        busy      [2];
   logic        perr      [2];

   int checks   = 0;
   int failures = 0;

   // Reference model: per-instance word array, known-word flags, and the
   // read data each instance should currently be holding.
   logic [31:0] ref_mem [2][1024];
   bit          known   [2][1024];
   logic [31:0] last_rd [2];

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_BITS(10), .LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst),
      .mem_read(mem_read[0]), .mem_write(mem_write[0]),
      .mem_byte_enable(be[0]), .mem_address(addr[0]), .mem_wdata(wdata[0]),
      .mem_rdata(rdata[0]), .mem_resp(resp[0]), .busy(busy[0]), .proto_err(perr[0])
   );

   data_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst),
      .mem_read(mem_read[1]), .mem_write(mem_write[1]),
      .mem_byte_enable(be[1]), .mem_address(addr[1]), .mem_wdata(wdata[1]),
      .mem_rdata(rdata[1]), .mem_resp(resp[1]), .busy(busy[1]), .proto_err(perr[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      for (int u = 0; u < 2; u++) begin
         mem_read[u]  = 1'b0;
         mem_write[u] = 1'b0;
         be[u]        = 4'h0;
         addr[u]      = '0;
         wdata[u]     = '0;
      end
   endtask

   // Leaves the bench at posedge+1 with reset released.
   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
   endtask

   // Call at posedge+1 with the target instance idle. Drives one request,
   // holds it through RESP, and returns at posedge+1 of the cycle after RESP.
   task automatic txn(input int u, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, output logic [31:0] got);
      int          lat;
      int          seen;
      int          idx;
      logic [31:0] exp;
      lat  = (u == 0) ? 3 : 1;
      seen = -1;
      idx  = int'(a[11:2]);
      got  = '0;
      mem_read[u]  = rd;
      mem_write[u] = wr;
      addr[u]      = a;
      wdata[u]     = d;
      be[u]        = b;
      for (int k = 0; k <= lat + 2; k++) begin
         @(negedge clk);
         if (resp[u]) begin
            seen = k;
            got  = rdata[u];
         end else if (k > 0) begin
            check("busy_wait", busy[u], 1'b1);
         end
         @(posedge clk);
         #1;
         if (seen >= 0) break;
      end
      mem_read[u]  = 1'b0;
      mem_write[u] = 1'b0;
      check("resp_latency", seen, lat);

      if (wr) begin
         check("rdata_hold", got, last_rd[u]);
         for (int i = 0; i < 4; i++)
            if (b[i]) ref_mem[u][idx][8*i +: 8] = d[8*i +: 8];
         if (b == 4'hF) known[u][idx] = 1'b1;
      end else if (known[u][idx]) begin
         exp = ref_mem[u][idx];
         check("rdata", got, exp);
         last_rd[u] = exp;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      int          base [8];
      rst = 1'b1;
      last_rd[0] = '0;
      last_rd[1] = '0;
      do_reset();

      // Reset state of both instances.
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check("rst_resp",  resp[u],  1'b0);
         check("rst_busy",  busy[u],  1'b0);
         check("rst_perr",  perr[u],  1'b0);
         check("rst_rdata", rdata[u], 32'h0);
      end
      @(posedge clk); #1;

      // Test 1: write then read back at LATENCY=3, back to back.
      txn(0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF, got);
      txn(0, 1, 0, 32'h100, 32'h0, 4'h0, got);
      check("t1_read", got, 32'hDEADBEEF);

      // Test 2: single-lane writes.
      txn(0, 0, 1, 32'h100, 32'h000000AA, 4'b0001, got);
      txn(0, 0, 1, 32'h100, 32'h55000000, 4'b1000, got);
      txn(0, 1, 0, 32'h100, 32'h0, 4'h0, got);
      check("t2_lanes", got, 32'h55ADBEAA);

      // Zero byte enables leave the word untouched.
      txn(0, 0, 1, 32'h100, 32'h11111111, 4'b0000, got);
      txn(0, 1, 0, 32'h100, 32'h0, 4'h0, got);
      check("be_zero", got, 32'h55ADBEAA);

      // Test 3: aliasing above the index bits.
      txn(0, 0, 1, 32'h1004, 32'h12345678, 4'hF, got);
      txn(0, 1, 0, 32'h0004, 32'h0, 4'h0, got);
      check("t3_alias", got, 32'h12345678);

      // Test 4: drop the read during WAIT.
      txn(0, 0, 1, 32'h40, 32'hA5A5C3C3, 4'hF, got);
      mem_read[0] = 1'b1;
      addr[0]     = 32'h40;
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_busy_wait", busy[0], 1'b1);
      mem_read[0] = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_busy_after", busy[0], 1'b0);
      check("t4_perr", perr[0], 1'b1);
      check("t4_no_resp", resp[0], 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("t4_no_resp_late", resp[0], 1'b0);
      end
      @(posedge clk); #1;
      txn(0, 1, 0, 32'h40, 32'h0, 4'h0, got);
      check("t4_unchanged", got, 32'hA5A5C3C3);
      @(negedge clk);
      check("t4_perr_sticky", perr[0], 1'b1);
      @(posedge clk); #1;

      // Test 5: reset during a write's WAIT phase.
      txn(0, 0, 1, 32'h200, 32'h00000000, 4'hF, got);
      mem_write[0] = 1'b1;
      addr[0]      = 32'h200;
      wdata[0]     = 32'hFFFFFFFF;
      be[0]        = 4'hF;
      @(posedge clk); #1;
      @(negedge clk);
      check("t5_busy", busy[0], 1'b1);
      rst          = 1'b1;
      mem_write[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      @(negedge clk);
      check("t5_resp",  resp[0],  1'b0);
      check("t5_busy0", busy[0],  1'b0);
      check("t5_perr",  perr[0],  1'b0);
      check("t5_rdata", rdata[0], 32'h0);
      repeat (3) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("t5_no_resp", resp[0], 1'b0);
      end
      @(posedge clk); #1;
      txn(0, 1, 0, 32'h200, 32'h0, 4'h0, got);
      check("t5_read", got, 32'h00000000);

      // Test 6: LATENCY=1, reads held continuously.
      txn(1, 0, 1, 32'h80, 32'h0BADF00D, 4'hF, got);
      mem_read[1] = 1'b1;
      addr[1]     = 32'h80;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("t6_resp_pattern", resp[1], (k % 2 == 1));
         if (k % 2 == 1) check("t6_rdata", rdata[1], ref_mem[1][32]);
         @(posedge clk); #1;
      end
      mem_read[1] = 1'b0;
      last_rd[1]  = ref_mem[1][32];

      // Read and write raised together act as a write and set proto_err.
      txn(1, 1, 1, 32'h84, 32'hCAFEF00D, 4'hF, got);
      @(negedge clk);
      check("t6_both_perr", perr[1], 1'b1);
      @(posedge clk); #1;
      txn(1, 1, 0, 32'h84, 32'h0, 4'h0, got);
      check("t6_both_write", got, 32'hCAFEF00D);

      // Randomized traffic on both instances against the model.
      for (int j = 0; j < 8; j++) begin
         base[j] = int'($urandom_range(0, 1023));
         for (int u = 0; u < 2; u++)
            txn(u, 0, 1, {20'h0, base[j][9:0], 2'b00}, $urandom, 4'hF, got);
      end
      for (int n = 0; n < 60; n++) begin
         int          u;
         int          j;
         bit          wr;
         logic [31:0] a;
         u  = n % 2;
         j  = int'($urandom_range(0, 7));
         wr = 1'($urandom_range(0, 1));
         a  = {20'($urandom), base[j][9:0], 2'($urandom)};
         txn(u, !wr, wr, a, $urandom, 4'($urandom), got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
